// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXECUTE/MEM/WB with imem/dmem handshakes,
// retire counting and a sticky trap on illegal ctrl words or memory timeouts.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [6:0]  ctrl,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic        alu_src_imm,
    output logic        busy,
    output logic        trap,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP
    } state_t;

    // Last count value at which a still-unacked request gives up.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       retire;
    logic       timeout;
    logic       req_wait;

    assign timeout  = (wait_cnt == TO_LAST);
    assign req_wait = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state && (state_nxt == FETCH || state_nxt == MEM))
                wait_cnt <= '0;
            else if (req_wait)
                wait_cnt <= wait_cnt + 8'd1;
            if (retire)
                retired <= retired + 32'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'b00;
        rf_we       = 1'b0;
        alu_src_imm = 1'b0;
        busy        = 1'b0;
        trap        = 1'b0;
        retire      = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = DECODE;
                end else if (timeout) begin
                    state_nxt = TRAP;
                end
            end
            DECODE: begin
                busy = 1'b1;
                if (ctrl == 7'd0 || (ctrl[2] && ctrl[1])) state_nxt = TRAP;
                else                                      state_nxt = EXECUTE;
            end
            EXECUTE: begin
                busy        = 1'b1;
                alu_src_imm = ctrl[3];
                if (ctrl[2] || ctrl[1]) state_nxt = MEM;
                else if (ctrl[0])       state_nxt = WB;
                else                    retire    = 1'b1;
            end
            MEM: begin
                busy        = 1'b1;
                dmem_req    = 1'b1;
                dmem_we     = ctrl[1];
                alu_src_imm = 1'b1;
                if (dmem_ack) begin
                    if (ctrl[1]) retire    = 1'b1;
                    else         state_nxt = WB;
                end else if (timeout) begin
                    state_nxt = TRAP;
                end
            end
            WB: begin
                busy   = 1'b1;
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        // Jump beats a taken branch; the retire cycle also picks the next fetch.
        if (retire) begin
            pc_we     = 1'b1;
            pc_sel    = ctrl[4] ? 2'b10 : ((ctrl[5] && branch_taken) ? 2'b01 : 2'b00);
            state_nxt = run ? FETCH : IDLE;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32 core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, driving the instruction-memory and data-memory request/ack handshakes. It consumes the decoder's 7-bit `ctrl` word and the ALU branch result, and produces the per-cycle enables for the IR, PC, register file and ALU operand mux. It also counts retired instructions and traps on illegal opcodes or memory timeouts.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum consecutive cycles a request may wait for its ack before trapping; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  core clock
- reset_n  in  1  reset; one clock, asynchronous, active-low
- run  in  1  start/continue execution; sampled only in IDLE and in retire cycles
- ctrl  in  7  decoder ctrl word: [6] auipc, [5] branch, [4] jump, [3] immediate, [2] memRead, [1] memWrite, [0] regWrite
- branch_taken  in  1  ALU compare result; valid in EXECUTE only
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store); meaningful only when dmem_req=1
- dmem_ack  in  1  data access complete this cycle
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  next-PC select: 00 pc+4, 01 pc+immed (branch), 10 pc+joffset (jump); 11 never driven
- rf_we  out  1  register file write
- alu_src_imm  out  1  ALU operand B = immediate
- busy  out  1  high in every state except IDLE and TRAP
- trap  out  1  sticky fault flag
- retired  out  32  retired instruction count, wraps 0xFFFFFFFF -> 0

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP. The state register is the only state besides the wait counter and `retired`.
- All outputs are decoded combinationally from the state plus `ctrl` and the acks. They are 0 unless stated otherwise.
- IDLE: when run=1, go to FETCH next cycle.
- FETCH: imem_req=1 every cycle. In the cycle imem_ack=1, assert ir_we=1 and go to DECODE.
- DECODE: one cycle, no outputs asserted.
  - ctrl==0 goes to TRAP.
  - ctrl[2]&ctrl[1] both set goes to TRAP.
  - Anything else goes to EXECUTE.
- EXECUTE: one cycle; alu_src_imm=ctrl[3].
  - memRead or memWrite: go to MEM.
  - Else regWrite: go to WB.
  - Else (branch, jump or no-op): this is the retire cycle.
- MEM: dmem_req=1, dmem_we=ctrl[1], alu_src_imm=1.
  - On dmem_ack with a load: go to WB.
  - On dmem_ack with a store: this is the retire cycle.
- WB: rf_we=1 for one cycle; this is the retire cycle.
- Retire cycle, exactly one per instruction:
  - pc_we=1.
  - pc_sel=10 if ctrl[4]; else 01 if ctrl[5]&branch_taken; else 00.
  - retired increments by 1.
  - Next state is FETCH if run=1, else IDLE.
- Timeout: the wait counter clears on entry to FETCH or MEM and increments each cycle with req=1 and ack=0. When it reaches MEM_TIMEOUT:
  - go to TRAP;
  - req drops the next cycle;
  - no retire occurs.
- TRAP: trap=1. All other outputs are 0, including busy. It is left only by reset.
- Acks are ignored while the matching req=0.

## Timing
- Reset (asynchronous, active-low):
  - state = IDLE;
  - retired = 0;
  - wait counter = 0;
  - every output 0 while reset_n=0 and in the first cycle after release.
- Assertion mid-instruction aborts immediately: req drops and no PC or RF write occurs.
- An ack may arrive in the first cycle a req is high. Latency with zero-wait memory, counted from FETCH entry to the retire cycle inclusive:
  - R/I type: 4 cycles;
  - load: 5 cycles;
  - store: 4 cycles;
  - branch/jump: 3 cycles.
- Each memory wait cycle adds 1 to the latency.
- imem_req and dmem_req stay high continuously until ack or timeout, never gapped.
- run=0 in mid-instruction does not abort the instruction. The FSM completes it and enters IDLE after retire.
- Back-to-back instructions: the retire cycle is followed immediately by FETCH, with no bubble.

## Test plan
- Reset, run=1, ctrl=7'b1000001, acks tied high: sequence FETCH/DECODE/EXECUTE/WB; rf_we only in cycle 4; pc_we with pc_sel=00 in cycle 4; retired=1.
- Load ctrl=7'b0001101, dmem_ack delayed 3 cycles: dmem_req high for 4 cycles with dmem_we=0; rf_we one cycle after ack; retire at cycle 8.
- Branch ctrl=7'b0101000: with branch_taken=1, pc_we=1 and pc_sel=01 in EXECUTE; repeat with branch_taken=0, pc_sel=00; no rf_we or dmem_req either time. Jump 7'b0010000 gives pc_sel=10.
- ctrl=0 in DECODE: TRAP, trap=1, busy=0, retired unchanged; stays in TRAP regardless of run and acks until reset_n pulses low.
- Store with dmem_ack never asserted, MEM_TIMEOUT=4: dmem_req=1 and dmem_we=1 for 4 cycles, then trap=1 and dmem_req=0; no pc_we.
- Run dropped during EXECUTE of an R-type: WB still retires, then IDLE with busy=0. Asserting reset_n low during a stalled FETCH clears imem_req immediately and returns to IDLE.
